data_plane_tx: RTL and testbench

- Transmit side of the data plane; drives the packet bus that feeds a remote node's data plane receiver.
- The GPP pushes 16-bit words into a local LIFO stack.
- On a grant from the control plane, the block pops BURST_LEN words and emits them one per cycle as 32-bit packets {dest_id, data}, then pulses a completion flag.
- LIFO pop order is intentional: the receiver stacks words and the GPP pops them back, so original order is restored end to end.

---
 rtl/data_plane_tx.sv | 125 ++++++++++++
 tb/tb_data_plane_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_plane_tx.sv
// Transmit side of the data plane: GPP words are stacked in a LIFO and, on a
// control-plane grant, popped out as a fixed-length burst of {dest_id, data} packets.
module data_plane_tx #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned BURST_LEN = 5,
    parameter logic [15:0] IDLE_ID   = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       gpp_wr_en,
    input  logic [15:0]                gpp_wr_data,
    input  logic [15:0]                dest_id,
    input  logic                       tx_start,
    output logic [31:0]                data_tx_packet,
    output logic                       tx_busy,
    output logic                       tx_full,
    output logic                       tx_empty,
    output logic [$clog2(DEPTH+1)-1:0] tx_level,
    output logic                       data_tx_complete_flag,
    output logic                       tx_error
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state, state_d;
    logic [LW-1:0]  sp, sp_d;
    logic [BW-1:0]  beat, beat_d;
    logic [15:0]    dest_q, dest_d;
    logic [31:0]    pkt_d;
    logic           cmpl_d;
    logic           err_d;
    logic           push_c;
    logic [15:0]    mem [DEPTH];
    logic [15:0]    rd_data;

    // Top of stack; only consumed when sp is non-zero.
    assign rd_data  = mem[AW'(sp - LW'(1))];

    assign tx_busy  = (state != IDLE);
    assign tx_full  = (sp == LW'(DEPTH));
    assign tx_empty = (sp == LW'(0));
    assign tx_level = sp;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        sp_d    = sp;
        beat_d  = beat;
        dest_d  = dest_q;
        pkt_d   = {IDLE_ID, 16'h0000};
        cmpl_d  = 1'b0;
        err_d   = 1'b0;
        push_c  = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start && (sp >= LW'(BURST_LEN))) begin
                    dest_d  = dest_id;
                    pkt_d   = {dest_id, rd_data};
                    sp_d    = sp - LW'(1);
                    beat_d  = BW'(1);
                    state_d = SEND;
                    err_d   = gpp_wr_en;
                end else begin
                    // A rejected start still lets a concurrent push through.
                    if (tx_start) begin
                        err_d = 1'b1;
                    end
                    if (gpp_wr_en) begin
                        if (!tx_full) begin
                            push_c = 1'b1;
                            sp_d   = sp + LW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            SEND: begin
                err_d = gpp_wr_en;
                if (beat < BW'(BURST_LEN)) begin
                    pkt_d  = {dest_q, rd_data};
                    sp_d   = sp - LW'(1);
                    beat_d = beat + BW'(1);
                end else begin
                    cmpl_d  = 1'b1;
                    beat_d  = BW'(0);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= IDLE;
            sp                    <= LW'(0);
            beat                  <= BW'(0);
            dest_q                <= IDLE_ID;
            data_tx_packet        <= {IDLE_ID, 16'h0000};
            data_tx_complete_flag <= 1'b0;
            tx_error              <= 1'b0;
        end else begin
            state                 <= state_d;
            sp                    <= sp_d;
            beat                  <= beat_d;
            dest_q                <= dest_d;
            data_tx_packet        <= pkt_d;
            data_tx_complete_flag <= cmpl_d;
            tx_error              <= err_d;
        end
    end

    // Stack storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[AW'(sp)] <= gpp_wr_data;
        end
    end

endmodule

// File: tb/tb_data_plane_tx.sv
// Self-checking bench for data_plane_tx: directed scenarios plus randomized
// traffic against a queue-based stack model.
module tb_data_plane_tx;

    localparam int DEPTH = 16;
    localparam int BURST = 5;
    localparam logic [31:0] IDLE_PKT = 32'hFFFF0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        gpp_wr_en;
    logic [15:0] gpp_wr_data;
    logic [15:0] dest_id;
    logic        tx_start;
    logic [31:0] data_tx_packet;
    logic        tx_busy, tx_full, tx_empty;
    logic [4:0]  tx_level;
    logic        data_tx_complete_flag;
    logic        tx_error;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stack contents, packets already sent in current burst.
    logic [15:0] stk[$];
    int          sent;
    logic [15:0] mdest;
    logic [31:0] exp_pkt;
    logic        exp_cmpl, exp_err;

    data_plane_tx dut (
        .clk                   (clk),
        .rst                   (rst),
        .gpp_wr_en             (gpp_wr_en),
        .gpp_wr_data           (gpp_wr_data),
        .dest_id               (dest_id),
        .tx_start              (tx_start),
        .data_tx_packet        (data_tx_packet),
        .tx_busy               (tx_busy),
        .tx_full               (tx_full),
        .tx_empty              (tx_empty),
        .tx_level              (tx_level),
        .data_tx_complete_flag (data_tx_complete_flag),
        .tx_error              (tx_error)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic wr, input logic [15:0] wd, input logic st, input logic [15:0] did);
        gpp_wr_en   = wr;
        gpp_wr_data = wd;
        tx_start    = st;
        dest_id     = did;
        @(posedge clk);
        exp_pkt  = IDLE_PKT;
        exp_cmpl = 1'b0;
        exp_err  = 1'b0;
        if (sent == 0) begin
            if (st && stk.size() >= BURST) begin
                mdest   = did;
                exp_pkt = {did, stk.pop_back()};
                sent    = 1;
                exp_err = wr;
            end else begin
                if (st) exp_err = 1'b1;
                if (wr) begin
                    if (stk.size() < DEPTH) stk.push_back(wd);
                    else exp_err = 1'b1;
                end
            end
        end else begin
            exp_err = wr;
            if (sent < BURST) begin
                exp_pkt = {mdest, stk.pop_back()};
                sent++;
            end else begin
                exp_cmpl = 1'b1;
                sent     = 0;
            end
        end
        #1;
        gpp_wr_en = 1'b0;
        tx_start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gpp_wr_en = 0; gpp_wr_data = 0; tx_start = 0; dest_id = 0;
        stk.delete(); sent = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (data_tx_packet !== IDLE_PKT) begin n_fail++; $display("FAIL reset_pkt got %h want %h", data_tx_packet, IDLE_PKT); end
        n_tests++;
        if (tx_empty !== 1'b1 || tx_level !== 5'd0 || tx_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_level got empty=%b level=%0d full=%b want 1 0 0", tx_empty, tx_level, tx_full);
        end
        n_tests++;
        if (data_tx_complete_flag !== 1'b0 || tx_error !== 1'b0 || tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got cmpl=%b err=%b busy=%b want 0 0 0", data_tx_complete_flag, tx_error, tx_busy);
        end
    endtask

    task automatic test_basic_burst();
        logic [31:0] want [BURST] = '{32'h00030055, 32'h00030044, 32'h00030033, 32'h00030022, 32'h00030011};
        logic [15:0] words [BURST] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
        for (int i = 0; i < BURST; i++) step(1'b1, words[i], 1'b0, 16'h0);
        for (int i = 0; i < BURST; i++) begin
            step(1'b0, 16'h0, (i == 0), 16'h0003);
            n_tests++;
            if (data_tx_packet !== want[i] || tx_busy !== 1'b1) begin
                n_fail++; $display("FAIL burst_pkt%0d got %h busy=%b want %h busy=1", i, data_tx_packet, tx_busy, want[i]);
            end
        end
        step(1'b0, 16'h0, 1'b0, 16'h0);
        n_tests++;
        if (data_tx_packet !== IDLE_PKT || data_tx_complete_flag !== 1'b1 || tx_level !== 5'd0) begin
            n_fail++; $display("FAIL burst_done got pkt=%h cmpl=%b level=%0d want ffff0000 1 0", data_tx_packet, data_tx_complete_flag, tx_level);
        end
        step(1'b0, 16'h0, 1'b0, 16'h0);
        n_tests++;
        if (data_tx_complete_flag !== 1'b0 || tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL burst_pulse_width got cmpl=%b busy=%b want 0 0", data_tx_complete_flag, tx_busy);
        end
    endtask

    task automatic test_insufficient();
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'hA0 + i), 1'b0, 16'h0);
        step(1'b0, 16'h0, 1'b1, 16'h0007);
        n_tests++;
        if (tx_error !== 1'b1 || data_tx_packet !== IDLE_PKT || tx_level !== 5'd3 || tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL short_start got err=%b pkt=%h level=%0d busy=%b want 1 ffff0000 3 0", tx_error, data_tx_packet, tx_level, tx_busy);
        end
        step(1'b0, 16'h0, 1'b0, 16'h0);
        n_tests++;
        if (tx_error !== 1'b0 || data_tx_packet !== IDLE_PKT) begin
            n_fail++; $display("FAIL short_after got err=%b pkt=%h want 0 ffff0000", tx_error, data_tx_packet);
        end
    endtask

    task automatic test_overflow();
        while (stk.size() < DEPTH) step(1'b1, 16'($urandom), 1'b0, 16'h0);
        n_tests++;
        if (tx_full !== 1'b1 || tx_level !== 5'd16 || tx_error !== 1'b0) begin
            n_fail++; $display("FAIL ovf_full got full=%b level=%0d err=%b want 1 16 0", tx_full, tx_level, tx_error);
        end
        step(1'b1, 16'hDEAD, 1'b0, 16'h0);
        n_tests++;
        if (tx_error !== 1'b1 || tx_level !== 5'd16) begin
            n_fail++; $display("FAIL ovf_drop got err=%b level=%0d want 1 16", tx_error, tx_level);
        end
    endtask

    task automatic test_push_during_send();
        int pre;
        pre = stk.size();
        for (int i = 0; i <= BURST; i++) begin
            step((i == 2), 16'hBEEF, (i == 0), 16'h0042);
            n_tests++;
            if (data_tx_packet !== exp_pkt || tx_error !== exp_err || data_tx_complete_flag !== exp_cmpl) begin
                n_fail++; $display("FAIL send_push%0d got pkt=%h err=%b cmpl=%b want %h %b %b",
                                   i, data_tx_packet, tx_error, data_tx_complete_flag, exp_pkt, exp_err, exp_cmpl);
            end
        end
        n_tests++;
        if (int'(tx_level) !== pre - BURST) begin
            n_fail++; $display("FAIL send_push_level got %0d want %0d", tx_level, pre - BURST);
        end
    endtask

    task automatic test_async_reset();
        while (stk.size() < BURST) step(1'b1, 16'($urandom), 1'b0, 16'h0);
        step(1'b0, 16'h0, 1'b1, 16'h0009);
        step(1'b0, 16'h0, 1'b0, 16'h0);
        #3 rst = 1'b1;
        #1;
        stk.delete(); sent = 0;
        n_tests++;
        if (data_tx_packet !== IDLE_PKT || tx_level !== 5'd0 || tx_busy !== 1'b0 || tx_empty !== 1'b1) begin
            n_fail++; $display("FAIL async_rst got pkt=%h level=%0d busy=%b empty=%b want ffff0000 0 0 1",
                               data_tx_packet, tx_level, tx_busy, tx_empty);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0);
            n_tests++;
            if (data_tx_complete_flag !== 1'b0 || data_tx_packet !== IDLE_PKT) begin
                n_fail++; $display("FAIL async_rst_after%0d got cmpl=%b pkt=%h want 0 ffff0000", i, data_tx_complete_flag, data_tx_packet);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step(($urandom % 3) != 0, 16'($urandom), ($urandom % 5) == 0, 16'($urandom_range(0, 16'hFFFE)));
            n_tests++;
            if (data_tx_packet !== exp_pkt || tx_error !== exp_err || data_tx_complete_flag !== exp_cmpl ||
                int'(tx_level) !== stk.size() || tx_busy !== (sent != 0) ||
                tx_full !== (stk.size() == DEPTH) || tx_empty !== (stk.size() == 0)) begin
                n_fail++;
                $display("FAIL rand%0d got pkt=%h err=%b cmpl=%b level=%0d busy=%b want %h %b %b %0d %b",
                         c, data_tx_packet, tx_error, data_tx_complete_flag, tx_level, tx_busy,
                         exp_pkt, exp_err, exp_cmpl, stk.size(), (sent != 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_insufficient();
        test_overflow();
        test_push_during_send();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
